// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the memory bus transaction controller.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESPOND,
      ST_FAULT
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_CONFLICT = 2'b11
   } err_e;

   // Access size as encoded in data_type[1:0]; 2'b11 is treated as a word.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Handshaked external memory/peripheral bus: the controller is the master.
interface mem_bus_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  valid;
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  ready;
   logic [31:0]           rdata;

   modport master (
      output valid, write, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, write, addr, wdata, wstrb,
      output ready, rdata
   );

endinterface

// File: rtl/mem_bus_ctrl_lane_align.sv
// Places a low-aligned store word into its byte lanes, builds the byte
// strobes, and flags accesses that do not sit on their natural boundary.
module mem_lane_align
   import mem_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic        misaligned
);

   always_comb begin
      // NOTE: every output gets a value before the case so no path can infer a latch.
      wdata      = store_data << {offset, 3'b000};
      wstrb      = 4'b1111;
      misaligned = 1'b0;
      unique case (size)
         SZ_BYTE: wstrb = 4'b0001 << offset;
         SZ_HALF: begin
            wstrb      = 4'b0011 << offset;
            misaligned = offset[0];
         end
         default: misaligned = |offset;
      endcase
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus-side load/store controller: accepts one request from IDLE, runs the
// handshaked bus access, and reports completion, misalignment or timeout.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_store,
   input  logic                  req_load,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [2:0]            data_type,
   input  logic [31:0]           store_data,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            err_code,
   output logic [1:0]            data_offset,
   output logic                  io_load,
   output logic [31:0]           io_data,
   mem_bus_if.master             bus
);

   // Width stays at least 1 so a disabled timeout still elaborates.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e                state, next_state;
   logic [CNT_W-1:0]      wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   err_e                  err_q;
   logic [1:0]            offset_q;
   logic [31:0]           rdata_q;

   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata;
   logic        misaligned;
   logic        conflict, single_req, timed_out;
   logic        unused_type;

   assign unused_type = data_type[2];
   assign conflict    = req_store && req_load;
   assign single_req  = req_store ^ req_load;
   assign timed_out   = (TIMEOUT_CYCLES != 0) && ((wait_cnt + CNT_ONE) == CNT_LIMIT);

   mem_lane_align u_lane_align (
      .size       (data_type[1:0]),
      .offset     (address[1:0]),
      .store_data (store_data),
      .wstrb      (lane_wstrb),
      .wdata      (lane_wdata),
      .misaligned (misaligned)
   );

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = (state != ST_IDLE);
      done       = 1'b0;
      io_load    = 1'b0;
      bus.valid  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (conflict)                      next_state = ST_FAULT;
            else if (single_req && misaligned) next_state = ST_FAULT;
            else if (single_req)               next_state = ST_ACCESS;
         end
         ST_ACCESS: begin
            bus.valid = 1'b1;
            if (bus.ready)      next_state = ST_RESPOND;
            else if (timed_out) next_state = ST_FAULT;
         end
         ST_RESPOND: begin
            done       = 1'b1;
            io_load    = !write_q;
            next_state = ST_IDLE;
         end
         default: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: datapath registers are reset too so every output reads 0 straight after reset.
      if (reset) begin
         wait_cnt <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         err_q    <= ERR_NONE;
         offset_q <= '0;
         rdata_q  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (conflict) begin
                  err_q <= ERR_CONFLICT;
               end else if (single_req) begin
                  offset_q <= address[1:0];
                  if (misaligned) begin
                     err_q <= ERR_MISALIGN;
                  end else begin
                     err_q    <= ERR_NONE;
                     addr_q   <= {address[ADDR_WIDTH-1:2], 2'b00};
                     write_q  <= req_store;
                     wdata_q  <= lane_wdata;
                     wstrb_q  <= req_store ? lane_wstrb : 4'b0000;
                     wait_cnt <= '0;
                  end
               end
            end
            ST_ACCESS: begin
               if (bus.ready) begin
                  if (!write_q) rdata_q <= bus.rdata;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
                  if (timed_out) err_q <= ERR_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.write   = write_q;
   assign bus.addr    = addr_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign err_code    = err_q;
   assign data_offset = offset_q;
   assign io_data     = rdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a short timeout so the timeout path
// is reachable; expected values are written out by hand per scenario.
module tb_mem_bus_ctrl;

   logic        clock;
   logic        reset;
   logic        req_store, req_load;
   logic [31:0] address;
   logic [2:0]  data_type;
   logic [31:0] store_data;
   logic        busy, done, io_load;
   logic [1:0]  err_code, data_offset;
   logic [31:0] io_data;

   int vectors     = 0;
   int miscompares = 0;

   mem_bus_if #(.ADDR_WIDTH(32)) bus ();

   mem_bus_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_store   (req_store),
      .req_load    (req_load),
      .address     (address),
      .data_type   (data_type),
      .store_data  (store_data),
      .busy        (busy),
      .done        (done),
      .err_code    (err_code),
      .data_offset (data_offset),
      .io_load     (io_load),
      .io_data     (io_data),
      .bus         (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vectors++;
      if ({busy, done, io_load, bus.valid, bus.write} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, io_load, bus.valid, bus.write});
      end
      vectors++;
      if ({err_code, data_offset, bus.wstrb} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_codes: got %h expected 00", {err_code, data_offset, bus.wstrb});
      end
      vectors++;
      if ({bus.addr, bus.wdata, io_data} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 0", {bus.addr, bus.wdata, io_data});
      end
   endtask

   task automatic test_store_byte();
      address = 32'h1003; data_type = 3'b000; store_data = 32'h0000_00AB;
      req_store = 1'b1; bus.ready = 1'b1;
      tick();
      req_store = 1'b0;
      vectors++;
      if ({bus.valid, bus.write, busy, done} !== 4'b1110) begin
         miscompares++;
         $display("FAIL sb_access_ctrl: got %b expected 1110", {bus.valid, bus.write, busy, done});
      end
      vectors++;
      if (bus.addr !== 32'h1000) begin
         miscompares++;
         $display("FAIL sb_addr: got %h expected 00001000", bus.addr);
      end
      vectors++;
      if ({bus.wstrb, bus.wdata} !== {4'b1000, 32'hAB00_0000}) begin
         miscompares++;
         $display("FAIL sb_lanes: got %b/%h expected 1000/ab000000", bus.wstrb, bus.wdata);
      end
      tick();
      bus.ready = 1'b0;
      vectors++;
      if ({done, io_load, bus.valid, err_code} !== 5'b10000) begin
         miscompares++;
         $display("FAIL sb_done: got %b expected 10000", {done, io_load, bus.valid, err_code});
      end
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL sb_idle: got %b expected 00", {done, busy});
      end
   endtask

   task automatic test_load_half();
      address = 32'h2002; data_type = 3'b001; store_data = 32'h5555_5555;
      req_load = 1'b1; bus.ready = 1'b0;
      tick();
      req_load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         vectors++;
         if ({bus.valid, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL lh_wait%0d: got %b expected 10", i, {bus.valid, done});
         end
         tick();
      end
      bus.ready = 1'b1; bus.rdata = 32'hBEEF_1234;
      vectors++;
      if ({bus.valid, bus.write, bus.wstrb, bus.addr} !== {1'b1, 1'b0, 4'b0000, 32'h2000}) begin
         miscompares++;
         $display("FAIL lh_bus: got %b%b%b/%h expected 100000/00002000", bus.valid, bus.write, bus.wstrb, bus.addr);
      end
      tick();
      bus.ready = 1'b0; bus.rdata = 32'h0;
      vectors++;
      if ({done, io_load, err_code, data_offset} !== 6'b110010) begin
         miscompares++;
         $display("FAIL lh_done: got %b expected 110010", {done, io_load, err_code, data_offset});
      end
      vectors++;
      if (io_data !== 32'hBEEF_1234) begin
         miscompares++;
         $display("FAIL lh_io_data: got %h expected beef1234", io_data);
      end
      tick();
      vectors++;
      if ({done, io_load, busy, data_offset, io_data} !== {5'b00010, 32'hBEEF_1234}) begin
         miscompares++;
         $display("FAIL lh_hold: got %b/%h expected 00010/beef1234", {done, io_load, busy, data_offset}, io_data);
      end
   endtask

   task automatic test_misaligned();
      address = 32'h3001; data_type = 3'b010;
      req_load = 1'b1;
      tick();
      req_load = 1'b0;
      vectors++;
      if ({done, bus.valid, io_load, err_code, data_offset} !== 7'b1000101) begin
         miscompares++;
         $display("FAIL mis_fault: got %b expected 1000101", {done, bus.valid, io_load, err_code, data_offset});
      end
      vectors++;
      if (bus.addr !== 32'h2000) begin
         miscompares++;
         $display("FAIL mis_bus_untouched: got %h expected 00002000", bus.addr);
      end
      tick();
      vectors++;
      if ({done, busy, err_code} !== 4'b0001) begin
         miscompares++;
         $display("FAIL mis_err_hold: got %b expected 0001", {done, busy, err_code});
      end
   endtask

   task automatic test_timeout();
      int n;
      address = 32'h4000; data_type = 3'b010; store_data = 32'h1122_3344;
      req_store = 1'b1; bus.ready = 1'b0;
      tick();
      req_store = 1'b0;
      vectors++;
      if ({bus.wstrb, bus.wdata} !== {4'b1111, 32'h1122_3344}) begin
         miscompares++;
         $display("FAIL to_lanes: got %b/%h expected 1111/11223344", bus.wstrb, bus.wdata);
      end
      n = 0;
      while (bus.valid && n < 20) begin
         n++;
         tick();
      end
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL to_valid_cycles: got %0d expected 8", n);
      end
      vectors++;
      if ({done, bus.valid, err_code} !== 4'b1010) begin
         miscompares++;
         $display("FAIL to_fault: got %b expected 1010", {done, bus.valid, err_code});
      end
      tick();
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL to_idle: got %b expected 00", {busy, done});
      end
   endtask

   task automatic test_conflict();
      address = 32'h5000; data_type = 3'b010;
      req_store = 1'b1; req_load = 1'b1;
      tick();
      req_store = 1'b0; req_load = 1'b0;
      vectors++;
      if ({done, bus.valid, err_code} !== 4'b1011) begin
         miscompares++;
         $display("FAIL conflict: got %b expected 1011", {done, bus.valid, err_code});
      end
      tick();
      vectors++;
      if ({busy, done, bus.valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL conflict_idle: got %b expected 000", {busy, done, bus.valid});
      end
   endtask

   task automatic test_back_to_back();
      address = 32'h6002; data_type = 3'b001; store_data = 32'h0000_CAFE;
      req_store = 1'b1; bus.ready = 1'b1;
      tick();
      vectors++;
      if ({err_code, bus.wstrb, bus.wdata} !== {2'b00, 4'b1100, 32'hCAFE_0000}) begin
         miscompares++;
         $display("FAIL b2b_first: got %b/%b/%h expected 00/1100/cafe0000", err_code, bus.wstrb, bus.wdata);
      end
      address = 32'h6004; data_type = 3'b010; store_data = 32'hDEAD_BEEF;
      tick();
      vectors++;
      if ({done, bus.addr} !== {1'b1, 32'h6000}) begin
         miscompares++;
         $display("FAIL b2b_busy_ignore: got %b/%h expected 1/00006000", done, bus.addr);
      end
      tick();
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL b2b_gap: got %b expected 00", {busy, done});
      end
      tick();
      req_store = 1'b0;
      vectors++;
      if ({bus.valid, bus.addr, bus.wstrb, bus.wdata} !== {1'b1, 32'h6004, 4'b1111, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL b2b_second: got %b/%h/%b/%h expected 1/00006004/1111/deadbeef", bus.valid, bus.addr, bus.wstrb, bus.wdata);
      end
      tick();
      vectors++;
      if ({done, data_offset} !== 3'b100) begin
         miscompares++;
         $display("FAIL b2b_done: got %b expected 100", {done, data_offset});
      end
      bus.ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      address = 32'h7000; data_type = 3'b010; store_data = 32'h7777_7777;
      req_store = 1'b1; bus.ready = 1'b0;
      tick();
      req_store = 1'b0;
      tick();
      vectors++;
      if (bus.valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_pre: got %b expected 1", bus.valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({bus.valid, busy, done, io_load, bus.write, err_code, data_offset, bus.wstrb} !== 13'b0) begin
         miscompares++;
         $display("FAIL rst_mid_ctrl: got %b expected 0", {bus.valid, busy, done, io_load, bus.write, err_code, data_offset, bus.wstrb});
      end
      vectors++;
      if ({bus.addr, bus.wdata, io_data} !== 96'h0) begin
         miscompares++;
         $display("FAIL rst_mid_data: got %h expected 0", {bus.addr, bus.wdata, io_data});
      end
      tick();
      vectors++;
      if ({done, busy, bus.valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL rst_mid_no_done: got %b expected 000", {done, busy, bus.valid});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req_store = 1'b0; req_load = 1'b0;
      address = 32'h0; data_type = 3'b000; store_data = 32'h0;
      bus.ready = 1'b0; bus.rdata = 32'h0;
      test_reset();
      test_store_byte();
      test_load_half();
      test_misaligned();
      test_timeout();
      test_conflict();
      test_back_to_back();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
